fft_peak_finder: RTL and testbench

// - Downstream of the FFT core; consumes one frame of complex bins and finds the peak-magnitude bin.
// - Produces the frequency result and the fft_done pulse for the data-processing FSM.
// - Searches only the positive half-spectrum, skipping DC bins; flags malformed frames.

---
 rtl/fft_peak_finder_pkg.sv | 36 +++
 rtl/fft_peak_finder_if.sv | 37 +++
 rtl/fft_peak_finder_mag_sq.sv | 53 +++++
 rtl/fft_peak_finder.sv | 223 ++++++++++++++++++++++
 tb/tb_fft_peak_finder.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_peak_finder_pkg.sv
// rtl/fft_peak_finder_pkg.sv - shared constants, FSM state and pipeline tag types for fft_peak_finder
package fft_peak_pkg;

  localparam int DATA_W  = 16;
  localparam int N_FFT   = 1024;
  localparam int MIN_BIN = 2;
  localparam int BIN_HZ  = 977;

  localparam int BIN_W  = $clog2(N_FFT);
  localparam int MAG_W  = 2 * DATA_W + 1;
  localparam int FREQ_W = BIN_W + 20;

  localparam logic [BIN_W-1:0] MIN_BIN_IDX = BIN_W'(MIN_BIN);
  localparam logic [BIN_W-1:0] HALF_IDX    = BIN_W'(N_FFT / 2);
  localparam logic [BIN_W-1:0] LAST_IDX    = BIN_W'(N_FFT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Side-band travelling with each beat through the magnitude pipeline.
  typedef struct packed {
    logic             valid;
    logic             first;
    logic             last;
    logic [BIN_W-1:0] bin;
  } tag_t;

  // Positive half-spectrum with the DC region removed.
  function automatic logic is_candidate(input logic [BIN_W-1:0] bin);
    return (bin >= MIN_BIN_IDX) && (bin < HALF_IDX);
  endfunction

endpackage

// File: rtl/fft_peak_finder_if.sv
// rtl/fft_peak_finder_if.sv - bin stream in / peak result out bundle; PEAK_FREQ_CALC_EN adds peak_freq
interface fft_peak_if;
  import fft_peak_pkg::*;

  logic signed [DATA_W-1:0] fft_re;
  logic signed [DATA_W-1:0] fft_im;
  logic                     fft_valid;
  logic                     fft_sop;
  logic                     fft_eop;

  logic [BIN_W-1:0]         peak_bin;
  logic [MAG_W-1:0]         peak_mag;
  logic                     peak_valid;
  logic                     fft_done;
  logic                     frame_err;
  logic                     busy;
`ifdef PEAK_FREQ_CALC_EN
  logic [FREQ_W-1:0]        peak_freq;
`endif

  modport master (
    output fft_re, fft_im, fft_valid, fft_sop, fft_eop,
    input  peak_bin, peak_mag, peak_valid, fft_done, frame_err, busy
`ifdef PEAK_FREQ_CALC_EN
    , input peak_freq
`endif
  );

  modport slave (
    input  fft_re, fft_im, fft_valid, fft_sop, fft_eop,
    output peak_bin, peak_mag, peak_valid, fft_done, frame_err, busy
`ifdef PEAK_FREQ_CALC_EN
    , output peak_freq
`endif
  );

endinterface

// File: rtl/fft_peak_finder_mag_sq.sv
// rtl/fft_peak_finder_mag_sq.sv - two-stage re^2+im^2 pipeline carrying a per-beat valid/bin tag
module fft_mag_sq
  import fft_peak_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic signed [DATA_W-1:0] re_i,
  input  logic signed [DATA_W-1:0] im_i,
  input  tag_t                     tag_i,
  output logic [MAG_W-1:0]         mag_o,
  output tag_t                     tag_o
);

  logic signed [2*DATA_W-1:0] re_ext;
  logic signed [2*DATA_W-1:0] im_ext;
  logic signed [2*DATA_W-1:0] re_sq_q;
  logic signed [2*DATA_W-1:0] im_sq_q;
  tag_t                       tag1_q;
  logic [MAG_W-1:0]           mag_q;
  tag_t                       tag2_q;

  // Sign-extend first so the product is taken at full width.
  assign re_ext = (2*DATA_W)'(re_i);
  assign im_ext = (2*DATA_W)'(im_i);

  // P1: square each component; squares are never negative.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      re_sq_q <= '0;
      im_sq_q <= '0;
      tag1_q  <= '0;
    end else begin
      re_sq_q <= re_ext * re_ext;
      im_sq_q <= im_ext * im_ext;
      tag1_q  <= tag_i;
    end
  end

  // P2: sum the squares with one guard bit so (-2^15)^2 * 2 cannot wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mag_q  <= '0;
      tag2_q <= '0;
    end else begin
      mag_q  <= {1'b0, re_sq_q} + {1'b0, im_sq_q};
      tag2_q <= tag1_q;
    end
  end

  assign mag_o = mag_q;
  assign tag_o = tag2_q;

endmodule

// File: rtl/fft_peak_finder.sv
// rtl/fft_peak_finder.sv - peak-magnitude bin search over one FFT frame; PEAK_FREQ_CALC_EN adds peak_freq stage
module fft_peak_finder
  import fft_peak_pkg::*;
(
  input logic       clk,
  input logic       reset_n,
  fft_peak_if.slave bus
);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] cnt_q, cnt_d;
  tag_t             tag_in;
  logic             err_d, err_q;

  logic [MAG_W-1:0] mag_p2;
  tag_t             tag_p2;

  logic [MAG_W-1:0] max_q, max_d, base_max;
  logic [BIN_W-1:0] arg_q, arg_d, base_arg;
  logic             res_now;
  logic             out_load;

  logic [BIN_W-1:0] peak_bin_q;
  logic [MAG_W-1:0] peak_mag_q;
  logic             peak_valid_q;

  fft_mag_sq u_mag_sq (
    .clk     (clk),
    .reset_n (reset_n),
    .re_i    (bus.fft_re),
    .im_i    (bus.fft_im),
    .tag_i   (tag_in),
    .mag_o   (mag_p2),
    .tag_o   (tag_p2)
  );

  // FSM and bin counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Frame framing: tag accepted beats, detect malformed frames, track drain.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tag_in  = '0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.fft_valid && bus.fft_sop) begin
          if (bus.fft_eop) begin
            err_d = 1'b1;
          end else begin
            state_d      = SCAN;
            cnt_d        = BIN_W'(1);
            tag_in.valid = 1'b1;
            tag_in.first = 1'b1;
          end
        end
      end
      SCAN: begin
        if (bus.fft_valid) begin
          if (bus.fft_sop) begin
            // Abandon the running frame; this beat restarts as bin 0.
            err_d = 1'b1;
            if (bus.fft_eop) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d        = BIN_W'(1);
              tag_in.valid = 1'b1;
              tag_in.first = 1'b1;
            end
          end else if (bus.fft_eop) begin
            if (cnt_q == LAST_IDX) begin
              state_d      = FLUSH;
              cnt_d        = '0;
              tag_in.valid = 1'b1;
              tag_in.last  = 1'b1;
              tag_in.bin   = cnt_q;
            end else begin
              err_d   = 1'b1;
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else if (cnt_q == LAST_IDX) begin
            err_d   = 1'b1;
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d        = cnt_q + 1'b1;
            tag_in.valid = 1'b1;
            tag_in.bin   = cnt_q;
          end
        end
      end
      FLUSH: begin
        if (out_load) begin
          state_d = IDLE;
        end
        // A new frame may start while the previous result is still in flight.
        if (bus.fft_valid && bus.fft_sop) begin
          if (bus.fft_eop) begin
            err_d = 1'b1;
          end else begin
            state_d      = SCAN;
            cnt_d        = BIN_W'(1);
            tag_in.valid = 1'b1;
            tag_in.first = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // P3 compare: first beat clears the running max, strict > keeps the lowest bin on ties.
  always_comb begin
    base_max = tag_p2.first ? '0 : max_q;
    base_arg = tag_p2.first ? MIN_BIN_IDX : arg_q;
    max_d    = max_q;
    arg_d    = arg_q;
    if (tag_p2.valid) begin
      max_d = base_max;
      arg_d = base_arg;
      if (is_candidate(tag_p2.bin) && (mag_p2 > base_max)) begin
        max_d = mag_p2;
        arg_d = tag_p2.bin;
      end
    end
  end

  assign res_now = tag_p2.valid & tag_p2.last;

  // P3 running max registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      max_q <= '0;
      arg_q <= '0;
    end else begin
      max_q <= max_d;
      arg_q <= arg_d;
    end
  end

`ifdef PEAK_FREQ_CALC_EN
  logic [BIN_W-1:0]  res_bin_q;
  logic [MAG_W-1:0]  res_mag_q;
  logic              res_v_q;
  logic [FREQ_W-1:0] peak_freq_q;

  // Closing P3 result waits one stage so the Hz multiply gets its own cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_v_q   <= 1'b0;
      res_bin_q <= '0;
      res_mag_q <= '0;
    end else begin
      res_v_q <= res_now;
      if (res_now) begin
        res_bin_q <= arg_d;
        res_mag_q <= max_d;
      end
    end
  end

  assign out_load = res_v_q;

  // Output registers: held until the next result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
      peak_freq_q  <= '0;
    end else begin
      peak_valid_q <= out_load;
      if (out_load) begin
        peak_bin_q  <= res_bin_q;
        peak_mag_q  <= res_mag_q;
        peak_freq_q <= FREQ_W'(res_bin_q) * FREQ_W'(BIN_HZ);
      end
    end
  end

  assign bus.peak_freq = peak_freq_q;
`else
  assign out_load = res_now;

  // Output registers: held until the next result.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      peak_valid_q <= 1'b0;
      peak_bin_q   <= '0;
      peak_mag_q   <= '0;
    end else begin
      peak_valid_q <= out_load;
      if (out_load) begin
        peak_bin_q <= arg_d;
        peak_mag_q <= max_d;
      end
    end
  end
`endif

  assign bus.peak_bin   = peak_bin_q;
  assign bus.peak_mag   = peak_mag_q;
  assign bus.peak_valid = peak_valid_q;
  assign bus.fft_done   = peak_valid_q;
  assign bus.frame_err  = err_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_fft_peak_finder.sv
// tb/tb_fft_peak_finder.sv - scoreboard bench for fft_peak_finder against a frame-level peak model
module tb_fft_peak_finder;
  import fft_peak_pkg::*;

`ifdef PEAK_FREQ_CALC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 3;
`endif

  typedef struct {
    bit     is_err;
    int     bin;
    longint mag;
    int     acc;
  } exp_t;

  logic clk;
  logic reset_n;
  fft_peak_if bus ();

  fft_peak_finder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   scan_open = 0;

  logic signed [DATA_W-1:0] fr_re[0:N_FFT-1];
  logic signed [DATA_W-1:0] fr_im[0:N_FFT-1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Frame-level reference: largest re^2+im^2 over MIN_BIN..N/2-1, first occurrence wins.
  function automatic void model_peak(output int bin, output longint mag);
    bin = MIN_BIN;
    mag = 0;
    for (int k = MIN_BIN; k < N_FFT / 2; k++) begin
      longint m;
      m = longint'(fr_re[k]) * longint'(fr_re[k]) + longint'(fr_im[k]) * longint'(fr_im[k]);
      if (m > mag) begin
        mag = m;
        bin = k;
      end
    end
  endfunction

  task automatic clear_frame();
    for (int k = 0; k < N_FFT; k++) begin
      fr_re[k] = '0;
      fr_im[k] = '0;
    end
  endtask

  task automatic set_bin(input int k, input int re, input int im);
    fr_re[k] = DATA_W'(re);
    fr_im[k] = DATA_W'(im);
  endtask

  task automatic drive_idle();
    bus.fft_valid = 1'b0;
    bus.fft_sop   = 1'b0;
    bus.fft_eop   = 1'b0;
    bus.fft_re    = DATA_W'($urandom);
    bus.fft_im    = DATA_W'($urandom);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.bin = 0; e.mag = 0; e.acc = cyc;
    sb.push_back(e);
  endtask

  task automatic push_result();
    exp_t e;
    e.is_err = 1'b0;
    model_peak(e.bin, e.mag);
    e.acc = cyc;
    sb.push_back(e);
  endtask

  // Send bins 0..last_idx with sop on bin 0; gap_mode 0 none, 1 alternate, 2 random.
  task automatic send_frame(input int last_idx, input bit with_eop, input int gap_mode, input bit expect_out);
    int n;
    for (int k = 0; k <= last_idx; k++) begin
      if (k > 0) begin
        n = 0;
        if (gap_mode == 1) n = 1;
        else if (gap_mode == 2 && $urandom_range(0, 3) == 0) n = $urandom_range(1, 3);
        repeat (n) begin
          drive_idle();
          @(posedge clk); #1;
        end
      end
      bus.fft_valid = 1'b1;
      bus.fft_sop   = (k == 0);
      bus.fft_eop   = with_eop && (k == last_idx);
      bus.fft_re    = fr_re[k];
      bus.fft_im    = fr_im[k];
      @(posedge clk); #1;
      if (k == 0) begin
        if (expect_out && (scan_open || (with_eop && last_idx == 0))) push_err();
        scan_open = 1'b0;
        check("busy_after_sop", bus.busy, !(with_eop && last_idx == 0));
      end
      if (k == last_idx && expect_out) begin
        if (with_eop) begin
          if (last_idx == N_FFT - 1) push_result();
          else if (last_idx != 0) push_err();
        end else begin
          if (last_idx == N_FFT - 1) push_err();
          else scan_open = 1'b1;
        end
      end
    end
    drive_idle();
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(posedge clk); #1;
    check("drain_pending", sb.size(), 0);
    check("busy_idle", bus.busy, 1'b0);
  endtask

  task automatic random_frame();
    int k;
    clear_frame();
    repeat ($urandom_range(1, 10)) set_bin($urandom_range(0, N_FFT - 1), int'($urandom), int'($urandom));
    if ($urandom_range(0, 1) == 1) begin
      k = $urandom_range(2, 500);
      set_bin(k, 20000, -20000);
      set_bin(k + 5, 20000, -20000);
    end
  endtask

  // Monitor: every result or error pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (reset_n && (bus.peak_valid || bus.frame_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: peak_valid=%0b frame_err=%0b expected none", bus.peak_valid, bus.frame_err);
      end else begin
        e = sb.pop_front();
        check("pulse_is_err", bus.frame_err, e.is_err);
        if (e.is_err) begin
          check("no_result_on_err", bus.peak_valid, 1'b0);
        end else begin
          check("peak_bin", bus.peak_bin, e.bin);
          check("peak_mag", bus.peak_mag, e.mag);
          check("fft_done", bus.fft_done, 1'b1);
          // eop cycle ends at edge A; cycle LAT after it starts at edge A+LAT-1.
          check("latency", 64'(cyc - e.acc), LAT - 1);
`ifdef PEAK_FREQ_CALC_EN
          check("peak_freq", bus.peak_freq, 64'(longint'(e.bin) * BIN_HZ));
`endif
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_peak_valid", bus.peak_valid, 0);
    check("rst_fft_done", bus.fft_done, 0);
    check("rst_frame_err", bus.frame_err, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_peak_bin", bus.peak_bin, 0);
    check("rst_peak_mag", bus.peak_mag, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk); #1;

    // Single tone at bin 100.
    clear_frame(); set_bin(100, 1000, -500);
    send_frame(N_FFT - 1, 1, 0, 1); wait_drain();

    // DC and mirror-half energy must be ignored; bin 512 is the first excluded bin.
    clear_frame();
    set_bin(0, 32767, 0); set_bin(1, 30000, 0); set_bin(1000, 20000, 0);
    set_bin(512, 30000, 0); set_bin(50, 10, 10); set_bin(511, 5, 5);
    send_frame(N_FFT - 1, 1, 0, 1); wait_drain();

    // Tie keeps the lower bin; valid toggles every other cycle.
    clear_frame(); set_bin(30, 300, 400); set_bin(40, 300, 400);
    send_frame(N_FFT - 1, 1, 1, 1); wait_drain();

    // All-zero frame and a most-negative corner at bin 2.
    clear_frame();
    send_frame(N_FFT - 1, 1, 0, 1); wait_drain();
    clear_frame(); set_bin(2, -32768, -32768); set_bin(511, 32767, 32767);
    send_frame(N_FFT - 1, 1, 0, 1); wait_drain();

    // Short frame, then a good frame.
    clear_frame(); set_bin(20, 100, 0);
    send_frame(511, 1, 0, 1); wait_drain();
    clear_frame(); set_bin(300, -700, 200);
    send_frame(N_FFT - 1, 1, 0, 1); wait_drain();

    // Sop arriving at bin 200 restarts the scan.
    clear_frame(); set_bin(100, 5000, 5000);
    send_frame(199, 0, 0, 1);
    clear_frame(); set_bin(7, 123, -45);
    send_frame(N_FFT - 1, 1, 0, 1); wait_drain();

    // Missing eop on the last bin, then a lone sop+eop beat.
    clear_frame(); set_bin(9, 9, 9);
    send_frame(N_FFT - 1, 0, 0, 1); wait_drain();
    send_frame(0, 1, 0, 1); wait_drain();

    // Back-to-back frames: second sop lands in the first frame's flush.
    random_frame(); send_frame(N_FFT - 1, 1, 0, 1);
    random_frame(); send_frame(N_FFT - 1, 1, 0, 1); wait_drain();

    // Randomised frames and gaps, including one random-length short frame.
    repeat (5) begin
      random_frame(); send_frame(N_FFT - 1, 1, 2, 1); wait_drain();
    end
    random_frame(); send_frame($urandom_range(10, N_FFT - 2), 1, 2, 1); wait_drain();

    // Reset right after eop: the in-flight result must never appear.
    clear_frame(); set_bin(77, 900, 900);
    send_frame(N_FFT - 1, 1, 0, 0);
    reset_n = 1'b0;
    @(negedge clk);
    check("midrst_peak_valid", bus.peak_valid, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_peak_bin", bus.peak_bin, 0);
    check("midrst_peak_mag", bus.peak_mag, 0);
    repeat (3) @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (8) @(posedge clk); #1;
    clear_frame(); set_bin(100, 1000, -500);
    send_frame(N_FFT - 1, 1, 0, 1); wait_drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
